// File: rtl/pu_master_spi_if.sv
// System-bus side of the SPI master PU: bus strobes, data/attr in, read port and frame flags.
interface pu_master_spi_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = 4
) ();
    logic                  signal_cycle;
    logic                  signal_wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic                  signal_oe;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;
    logic                  flag_start;
    logic                  flag_stop;

    modport master (
        output signal_cycle, signal_wr, data_in, attr_in, signal_oe,
        input  data_out, attr_out, flag_start, flag_stop
    );

    modport slave (
        input  signal_cycle, signal_wr, data_in, attr_in, signal_oe,
        output data_out, attr_out, flag_start, flag_stop
    );
endinterface

// File: rtl/pu_master_spi.sv
// SPI mode-0 master PU: shifts a bus word out MSB-first and captures the word returned on MISO.
module pu_master_spi #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ATTR_WIDTH       = 4,
    parameter int unsigned SCLK_HALF_PERIOD = 2
) (
    input  logic           clk,
    input  logic           rst,
    pu_master_spi_if.slave bus,
    output logic           mosi,
    input  logic           miso,
    output logic           sclk,
    output logic           cs
);
    localparam int unsigned HALF_W = $clog2(SCLK_HALF_PERIOD + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_HIGH, ST_LOW, ST_TRAIL} state_t;

    state_t                state, state_nx;
    logic [HALF_W-1:0]     half_cnt, half_nx;
    logic [BIT_W-1:0]      bit_cnt, bit_nx;
    logic [DATA_WIDTH-1:0] tx_hold, tx_hold_nx;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nx;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nx;
    logic [DATA_WIDTH-1:0] rx_result, rx_result_nx;
    logic                  flag_start_nx, flag_stop_nx;
    logic                  cs_nx, sclk_nx, mosi_nx;
    logic                  half_done_c;
    logic                  unused_attr;

    assign half_done_c = (half_cnt == HALF_W'(SCLK_HALF_PERIOD - 1));
    assign unused_attr = ^bus.attr_in;

    // Read port: no latency, gated by output enable
    assign bus.data_out = bus.signal_oe ? rx_result : '0;
    assign bus.attr_out = bus.signal_oe ? ATTR_WIDTH'(state != ST_IDLE) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            half_cnt       <= '0;
            bit_cnt        <= '0;
            tx_hold        <= '0;
            tx_shift       <= '0;
            rx_shift       <= '0;
            rx_result      <= '0;
            bus.flag_start <= 1'b0;
            bus.flag_stop  <= 1'b0;
            cs             <= 1'b1;
            sclk           <= 1'b0;
            mosi           <= 1'b0;
        end else begin
            state          <= state_nx;
            half_cnt       <= half_nx;
            bit_cnt        <= bit_nx;
            tx_hold        <= tx_hold_nx;
            tx_shift       <= tx_shift_nx;
            rx_shift       <= rx_shift_nx;
            rx_result      <= rx_result_nx;
            bus.flag_start <= flag_start_nx;
            bus.flag_stop  <= flag_stop_nx;
            cs             <= cs_nx;
            sclk           <= sclk_nx;
            mosi           <= mosi_nx;
        end
    end

    // Frame sequencer; each phase lasts SCLK_HALF_PERIOD cycles, the last LOW is folded into TRAIL
    always_comb begin
        state_nx      = state;
        half_nx       = half_cnt;
        bit_nx        = bit_cnt;
        tx_hold_nx    = bus.signal_wr ? bus.data_in : tx_hold;
        tx_shift_nx   = tx_shift;
        rx_shift_nx   = rx_shift;
        rx_result_nx  = rx_result;
        flag_start_nx = 1'b0;
        flag_stop_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.signal_cycle) begin
                    state_nx      = ST_LEAD;
                    half_nx       = '0;
                    bit_nx        = '0;
                    tx_shift_nx   = bus.signal_wr ? bus.data_in : tx_hold;
                    flag_start_nx = 1'b1;
                end
            end
            ST_LEAD, ST_LOW: begin
                if (!half_done_c) begin
                    half_nx = half_cnt + HALF_W'(1);
                end else begin
                    half_nx = '0;
                    if (bit_cnt < BIT_W'(DATA_WIDTH)) begin
                        state_nx    = ST_HIGH;
                        rx_shift_nx = {rx_shift[DATA_WIDTH-2:0], miso};
                    end else begin
                        state_nx = ST_TRAIL;
                    end
                end
            end
            ST_HIGH: begin
                if (!half_done_c) begin
                    half_nx = half_cnt + HALF_W'(1);
                end else begin
                    half_nx     = '0;
                    bit_nx      = bit_cnt + BIT_W'(1);
                    tx_shift_nx = tx_shift << 1;
                    state_nx    = (bit_cnt == BIT_W'(DATA_WIDTH - 1)) ? ST_TRAIL : ST_LOW;
                end
            end
            ST_TRAIL: begin
                if (!half_done_c) begin
                    half_nx = half_cnt + HALF_W'(1);
                end else begin
                    half_nx      = '0;
                    state_nx     = ST_IDLE;
                    rx_result_nx = rx_shift;
                    flag_stop_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // Pin values follow the next state so they come straight from flops
        cs_nx   = (state_nx == ST_IDLE);
        sclk_nx = (state_nx == ST_HIGH);
        mosi_nx = (state_nx == ST_LEAD || state_nx == ST_HIGH || state_nx == ST_LOW)
                  ? tx_shift_nx[DATA_WIDTH-1] : 1'b0;
    end
endmodule

// File: tb/tb_pu_master_spi.sv
// Directed bench for pu_master_spi: 32-bit/H=2 and 8-bit/H=1 instances with a mode-0 slave model.
module tb_pu_master_spi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pu_master_spi_if #(.DATA_WIDTH(32), .ATTR_WIDTH(4)) bus_a ();
    pu_master_spi_if #(.DATA_WIDTH(8),  .ATTR_WIDTH(4)) bus_b ();

    logic mosi_a, sclk_a, cs_a, miso_a = 1'b0;
    logic mosi_b, sclk_b, cs_b, miso_b = 1'b0;

    pu_master_spi #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SCLK_HALF_PERIOD(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .mosi(mosi_a), .miso(miso_a), .sclk(sclk_a), .cs(cs_a));
    pu_master_spi #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SCLK_HALF_PERIOD(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .mosi(mosi_b), .miso(miso_b), .sclk(sclk_b), .cs(cs_b));

    int unsigned n_cmp = 0, n_err = 0;

    // Slave model and monitors, all sampled on the falling clk edge
    logic [31:0] slv_a = '0, sh_a = '0, cap_a = '0;
    logic [7:0]  slv_b = '0, sh_b = '0, cap_b = '0;
    logic        cs_a_q = 1'b1, sclk_a_q = 1'b0, cs_b_q = 1'b1, sclk_b_q = 1'b0;
    int unsigned low_a = 0, rise_a = 0, fs_a = 0, fp_a = 0;
    int unsigned low_b = 0, rise_b = 0, fs_b = 0, fp_b = 0;
    int unsigned cyc = 0, last_rise_b = 0, per_b = 0;

    always @(negedge clk) begin
        cyc++;
        if (cs_a === 1'b0) low_a++;
        if (bus_a.flag_start === 1'b1) fs_a++;
        if (bus_a.flag_stop === 1'b1) fp_a++;
        if (cs_a === 1'b0 && cs_a_q === 1'b1) begin
            sh_a = slv_a; miso_a = sh_a[31];
        end else if (cs_a === 1'b0 && sclk_a_q === 1'b1 && sclk_a === 1'b0) begin
            sh_a = sh_a << 1; miso_a = sh_a[31];
        end
        if (sclk_a === 1'b1 && sclk_a_q === 1'b0) begin
            rise_a++; cap_a = {cap_a[30:0], mosi_a};
        end
        cs_a_q = cs_a; sclk_a_q = sclk_a;

        if (cs_b === 1'b0) low_b++;
        if (bus_b.flag_start === 1'b1) fs_b++;
        if (bus_b.flag_stop === 1'b1) fp_b++;
        if (cs_b === 1'b0 && cs_b_q === 1'b1) begin
            sh_b = slv_b; miso_b = sh_b[7];
        end else if (cs_b === 1'b0 && sclk_b_q === 1'b1 && sclk_b === 1'b0) begin
            sh_b = sh_b << 1; miso_b = sh_b[7];
        end
        if (sclk_b === 1'b1 && sclk_b_q === 1'b0) begin
            rise_b++; cap_b = {cap_b[6:0], mosi_b};
            per_b = cyc - last_rise_b; last_rise_b = cyc;
        end
        cs_b_q = cs_b; sclk_b_q = sclk_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit b, input logic cyc_v, input logic wr_v, input logic [31:0] d);
        if (b) begin
            bus_b.signal_cycle = cyc_v; bus_b.signal_wr = wr_v; bus_b.data_in = d[7:0];
        end else begin
            bus_a.signal_cycle = cyc_v; bus_a.signal_wr = wr_v; bus_a.data_in = d;
        end
    endtask

    task automatic write_word(input bit b, input logic [31:0] d);
        @(negedge clk); set_in(b, 1'b0, 1'b1, d);
        @(negedge clk); set_in(b, 1'b0, 1'b0, d);
    endtask

    task automatic pulse_cycle(input bit b, input bit with_wr, input logic [31:0] d);
        @(negedge clk); set_in(b, 1'b1, with_wr, d);
        @(negedge clk); set_in(b, 1'b0, 1'b0, d);
    endtask

    task automatic wait_stop(input bit b, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk); #1;
            if ((b ? bus_b.flag_stop : bus_a.flag_stop) === 1'b1) seen = 1'b1;
        end
    endtask

    // mode: 0 = write then cycle, 1 = write in the same cycle, 2 = send whatever tx_hold has
    task automatic do_frame(input bit b, input int mode, input logic [31:0] tx, input logic [31:0] slv,
                            input logic [31:0] exp_mosi, input logic [31:0] exp_rx,
                            input int unsigned exp_low, input int unsigned exp_bits, input string tag);
        int unsigned low0, rise0, fs0, fp0;
        bit seen;
        if (mode == 0) write_word(b, tx);
        if (b) slv_b = slv[7:0]; else slv_a = slv;
        low0 = b ? low_b : low_a; rise0 = b ? rise_b : rise_a;
        fs0 = b ? fs_b : fs_a;    fp0 = b ? fp_b : fp_a;
        pulse_cycle(b, mode == 1, tx);
        wait_stop(b, seen);
        chk({tag, "_stop_seen"}, 32'(seen), 32'd1);
        if (b) bus_b.signal_oe = 1'b1; else bus_a.signal_oe = 1'b1;
        #1;
        chk({tag, "_data_out"}, b ? 32'(bus_b.data_out) : bus_a.data_out, exp_rx);
        chk({tag, "_mosi"}, b ? 32'(cap_b) : cap_a, exp_mosi);
        chk({tag, "_cs_low"}, (b ? low_b : low_a) - low0, exp_low);
        chk({tag, "_sclk_rises"}, (b ? rise_b : rise_a) - rise0, exp_bits);
        chk({tag, "_n_start"}, (b ? fs_b : fs_a) - fs0, 32'd1);
        chk({tag, "_n_stop"}, (b ? fp_b : fp_a) - fp0, 32'd1);
        if (b) bus_b.signal_oe = 1'b0; else bus_a.signal_oe = 1'b0;
    endtask

    typedef struct {
        int          mode;
        logic [31:0] tx;
        logic [31:0] slv;
        logic [31:0] exp_mosi;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit seen;
        int unsigned low0, fs0, fp0;

        vecs[0] = '{mode: 0, tx: 32'hA5A50F0F, slv: 32'h12345678, exp_mosi: 32'hA5A50F0F, exp_rx: 32'h12345678};
        vecs[1] = '{mode: 0, tx: 32'hFFFFFFFF, slv: 32'h00000000, exp_mosi: 32'hFFFFFFFF, exp_rx: 32'h00000000};
        vecs[2] = '{mode: 0, tx: 32'h00000000, slv: 32'hFFFFFFFF, exp_mosi: 32'h00000000, exp_rx: 32'hFFFFFFFF};
        vecs[3] = '{mode: 1, tx: 32'hDEADBEEF, slv: 32'h80000001, exp_mosi: 32'hDEADBEEF, exp_rx: 32'h80000001};
        vecs[4] = '{mode: 2, tx: 32'h00000000, slv: 32'h3C3C3C3C, exp_mosi: 32'hDEADBEEF, exp_rx: 32'h3C3C3C3C};

        set_in(1'b0, 1'b0, 1'b0, 32'h0); set_in(1'b1, 1'b0, 1'b0, 32'h0);
        bus_a.attr_in = '0; bus_b.attr_in = '0;
        bus_a.signal_oe = 1'b0; bus_b.signal_oe = 1'b0;

        // Power-on reset
        repeat (3) @(negedge clk);
        #1;
        chk("por_cs", 32'(cs_a), 32'd1);
        chk("por_sclk", 32'(sclk_a), 32'd0);
        chk("por_mosi", 32'(mosi_a), 32'd0);
        chk("por_flags", {30'd0, bus_a.flag_start, bus_a.flag_stop}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            do_frame(1'b0, vecs[i].mode, vecs[i].tx, vecs[i].slv, vecs[i].exp_mosi, vecs[i].exp_rx,
                     130, 32, $sformatf("vec%0d", i));

        // Busy: write and cycle mid-frame must not disturb the frame or queue another
        write_word(1'b0, 32'hCAFEF00D);
        slv_a = 32'h0F0F0F0F;
        fs0 = fs_a;
        pulse_cycle(1'b0, 1'b0, 32'h0);
        repeat (20) @(negedge clk);
        set_in(1'b0, 1'b1, 1'b1, 32'h00000001);
        bus_a.signal_oe = 1'b1;
        #1;
        chk("busy_attr", 32'(bus_a.attr_out), 32'd1);
        chk("busy_old_data", bus_a.data_out, 32'h3C3C3C3C);
        @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 32'h0);
        wait_stop(1'b0, seen);
        chk("busy_stop_seen", 32'(seen), 32'd1);
        chk("busy_mosi", cap_a, 32'hCAFEF00D);
        chk("busy_data_out", bus_a.data_out, 32'h0F0F0F0F);
        chk("busy_idle_attr", 32'(bus_a.attr_out), 32'd0);
        bus_a.signal_oe = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("busy_no_requeue_cs", 32'(cs_a), 32'd1);
        chk("busy_no_requeue_start", fs_a - fs0, 32'd1);
        do_frame(1'b0, 2, 32'h0, 32'h55AA33CC, 32'h00000001, 32'h55AA33CC, 130, 32, "after_busy");

        // Back-to-back: cycle on the flag_stop cycle, second frame uses same-cycle write
        write_word(1'b0, 32'h13579BDF);
        slv_a = 32'h2468ACE0;
        pulse_cycle(1'b0, 1'b0, 32'h0);
        wait_stop(1'b0, seen);
        chk("b2b_stop1_seen", 32'(seen), 32'd1);
        chk("b2b_mosi1", cap_a, 32'h13579BDF);
        chk("b2b_cs_at_stop", 32'(cs_a), 32'd1);
        set_in(1'b0, 1'b1, 1'b1, 32'h0F1E2D3C);
        slv_a = 32'hA1B2C3D4;
        low0 = low_a; fp0 = fp_a;
        @(negedge clk); #1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        chk("b2b_cs_gap", 32'(cs_a), 32'd0);
        chk("b2b_start2", 32'(bus_a.flag_start), 32'd1);
        wait_stop(1'b0, seen);
        bus_a.signal_oe = 1'b1; #1;
        chk("b2b_stop2_seen", 32'(seen), 32'd1);
        chk("b2b_mosi2", cap_a, 32'h0F1E2D3C);
        chk("b2b_data2", bus_a.data_out, 32'hA1B2C3D4);
        chk("b2b_cs_low2", low_a - low0, 32'd130);
        chk("b2b_n_stop", fp_a - fp0, 32'd1);
        bus_a.signal_oe = 1'b0;

        // Reset mid-frame aborts without flag_stop and clears the result
        write_word(1'b0, 32'h55AA55AA);
        pulse_cycle(1'b0, 1'b0, 32'h0);
        repeat (30) @(negedge clk);
        fp0 = fp_a;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs", 32'(cs_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_mosi", 32'(mosi_a), 32'd0);
        chk("rst_flags", {30'd0, bus_a.flag_start, bus_a.flag_stop}, 32'd0);
        rst = 1'b0;
        bus_a.signal_oe = 1'b1; #1;
        chk("rst_data_out", bus_a.data_out, 32'h0);
        chk("rst_attr_out", 32'(bus_a.attr_out), 32'd0);
        bus_a.signal_oe = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_no_stop", fp_a - fp0, 32'd0);

        // Narrow instance: 8-bit frame, one clk per half-period
        do_frame(1'b1, 0, 32'h81, 32'h7E, 32'h81, 32'h7E, 17, 8, "b_81");
        chk("b_sclk_period", per_b, 32'd2);
        do_frame(1'b1, 1, 32'h3C, 32'hC3, 32'h3C, 32'hC3, 17, 8, "b_3c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
